// File: rtl/btrfly_r2_pipe.sv
// btrfly_r2_pipe: 3-stage radix-2 DIT butterfly (A +/- W*B) with rounding, saturation and stall handshake
module btrfly_r2_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH   = 16,
   parameter bit SCALE_EN   = 1'b1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic signed [DATA_WIDTH-1:0] i_a_real,
   input  logic signed [DATA_WIDTH-1:0] i_a_imag,
   input  logic signed [DATA_WIDTH-1:0] i_b_real,
   input  logic signed [DATA_WIDTH-1:0] i_b_imag,
   input  logic signed [TW_WIDTH-1:0]   i_w_real,
   input  logic signed [TW_WIDTH-1:0]   i_w_imag,
   input  logic                         i_tw_bypass,
   input  logic                         i_scale,
   input  logic                         i_ovf_clr,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic signed [DATA_WIDTH-1:0] o_sum_real,
   output logic signed [DATA_WIDTH-1:0] o_sum_imag,
   output logic signed [DATA_WIDTH-1:0] o_diff_real,
   output logic signed [DATA_WIDTH-1:0] o_diff_imag,
   output logic                         o_ovf
);
   localparam int DW = DATA_WIDTH;
   localparam int TW = TW_WIDTH;
   localparam int PW = DW + TW;
   localparam int SW = PW + 1;
   localparam int XW = DW + 2;
   localparam logic signed [TW-1:0] W_ONE = TW'(1 << (TW - 2));
   localparam logic signed [SW-1:0] RND   = SW'(1) <<< (TW - 3);
   localparam logic signed [SW-1:0] MX2   = (SW'(1) <<< DW) - SW'(1);
   localparam logic signed [SW-1:0] MN2   = -MX2 - SW'(1);
   localparam logic signed [XW-1:0] MX3   = (XW'(1) <<< (DW - 1)) - XW'(1);
   localparam logic signed [XW-1:0] MN3   = -MX3 - XW'(1);

   // {saturated, value} after Q2 round-half-up and clamp to DW+1 bits
   function automatic logic [DW+1:0] sat2(input logic signed [SW-1:0] x);
      logic signed [SW-1:0] y;
      y = (x + RND) >>> (TW - 2);
      return (y > MX2) ? {1'b1, MX2[DW:0]} : (y < MN2) ? {1'b1, MN2[DW:0]} : {1'b0, y[DW:0]};
   endfunction

   function automatic logic [DW:0] sat3(input logic signed [XW-1:0] x, input logic sc);
      logic signed [XW-1:0] y;
      y = sc ? (x + XW'(1)) >>> 1 : x;
      return (y > MX3) ? {1'b1, MX3[DW-1:0]} : (y < MN3) ? {1'b1, MN3[DW-1:0]} : {1'b0, y[DW-1:0]};
   endfunction

   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ovf_q, ovf_d;
   logic scl1_q, scl1_d, scl2_q, scl2_d, ovp2_q, ovp2_d;
   logic signed [DW-1:0] ar1_q, ar1_d, ai1_q, ai1_d, ar2_q, ar2_d, ai2_q, ai2_d;
   logic signed [DW-1:0] sr_q, sr_d, si_q, si_d, dr_q, dr_d, di_q, di_d;
   logic signed [PW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;
   logic signed [DW:0]   wbr_q, wbr_d, wbi_q, wbi_d;
   logic signed [PW-1:0] bre, bie, wre, wie;
   logic [DW+1:0]        r2, i2;
   logic [DW:0]          s_r, s_i, d_r, d_i;
   logic                 adv, ovf_set;

   // Bypass is realised as an exact unit twiddle, so S2 needs no separate B path
   always_comb begin
      adv     = i_ready || !v3_q;
      bre     = PW'(i_b_real);
      bie     = PW'(i_b_imag);
      wre     = i_tw_bypass ? PW'(W_ONE) : PW'(i_w_real);
      wie     = i_tw_bypass ? '0 : PW'(i_w_imag);
      r2      = sat2(SW'(prr_q) - SW'(pii_q));
      i2      = sat2(SW'(pri_q) + SW'(pir_q));
      s_r     = sat3(XW'(ar2_q) + XW'(wbr_q), scl2_q);
      s_i     = sat3(XW'(ai2_q) + XW'(wbi_q), scl2_q);
      d_r     = sat3(XW'(ar2_q) - XW'(wbr_q), scl2_q);
      d_i     = sat3(XW'(ai2_q) - XW'(wbi_q), scl2_q);
      ovf_set = v2_q && adv && (ovp2_q || s_r[DW] || s_i[DW] || d_r[DW] || d_i[DW]);
      v1_d    = adv ? i_valid : v1_q;
      ar1_d   = adv ? i_a_real : ar1_q;
      ai1_d   = adv ? i_a_imag : ai1_q;
      prr_d   = adv ? bre * wre : prr_q;
      pii_d   = adv ? bie * wie : pii_q;
      pri_d   = adv ? bre * wie : pri_q;
      pir_d   = adv ? bie * wre : pir_q;
      scl1_d  = adv ? (i_scale && SCALE_EN) : scl1_q;
      v2_d    = adv ? v1_q : v2_q;
      ar2_d   = adv ? ar1_q : ar2_q;
      ai2_d   = adv ? ai1_q : ai2_q;
      wbr_d   = adv ? r2[DW:0] : wbr_q;
      wbi_d   = adv ? i2[DW:0] : wbi_q;
      ovp2_d  = adv ? (r2[DW+1] || i2[DW+1]) : ovp2_q;
      scl2_d  = adv ? scl1_q : scl2_q;
      v3_d    = adv ? v2_q : v3_q;
      sr_d    = (adv && v2_q) ? s_r[DW-1:0] : sr_q;
      si_d    = (adv && v2_q) ? s_i[DW-1:0] : si_q;
      dr_d    = (adv && v2_q) ? d_r[DW-1:0] : dr_q;
      di_d    = (adv && v2_q) ? d_i[DW-1:0] : di_q;
      ovf_d   = ovf_set || (ovf_q && !i_ovf_clr);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; ovf_q <= 1'b0;
         scl1_q <= 1'b0; scl2_q <= 1'b0; ovp2_q <= 1'b0;
         ar1_q <= '0; ai1_q <= '0; ar2_q <= '0; ai2_q <= '0;
         prr_q <= '0; pii_q <= '0; pri_q <= '0; pir_q <= '0;
         wbr_q <= '0; wbi_q <= '0;
         sr_q <= '0; si_q <= '0; dr_q <= '0; di_q <= '0;
      end else begin
         v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; ovf_q <= ovf_d;
         scl1_q <= scl1_d; scl2_q <= scl2_d; ovp2_q <= ovp2_d;
         ar1_q <= ar1_d; ai1_q <= ai1_d; ar2_q <= ar2_d; ai2_q <= ai2_d;
         prr_q <= prr_d; pii_q <= pii_d; pri_q <= pri_d; pir_q <= pir_d;
         wbr_q <= wbr_d; wbi_q <= wbi_d;
         sr_q <= sr_d; si_q <= si_d; dr_q <= dr_d; di_q <= di_d;
      end
   end

   assign o_ready     = adv;
   assign o_valid     = v3_q;
   assign o_ovf       = ovf_q;
   assign o_sum_real  = sr_q;
   assign o_sum_imag  = si_q;
   assign o_diff_real = dr_q;
   assign o_diff_imag = di_q;
endmodule

// File: tb/tb_btrfly_r2_pipe.sv
// tb_btrfly_r2_pipe: directed and randomized checks of the butterfly against an arithmetic reference model
module tb_btrfly_r2_pipe;
   localparam int DW = 16;
   localparam int TW = 16;
   localparam longint ONE  = longint'(1) << (TW - 2);
   localparam longint HALF = longint'(1) << (TW - 3);

   typedef struct {int ar, ai, br, bi, wr, wi; bit byp, scl;} smp_t;
   typedef struct {int sr, si, dr, di; bit ovf;} res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_valid, o_ready, i_tw_bypass, i_scale, i_ovf_clr, o_valid, i_ready, o_ovf;
   logic signed [DW-1:0] i_a_real, i_a_imag, i_b_real, i_b_imag;
   logic signed [DW-1:0] o_sum_real, o_sum_imag, o_diff_real, o_diff_imag;
   logic signed [TW-1:0] i_w_real, i_w_imag;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   sticky  = 1'b0;
   res_t exp_q[$];
   smp_t z = '{default: 0};

   always #5 clk = ~clk;

   btrfly_r2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .SCALE_EN(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a_real(i_a_real), .i_a_imag(i_a_imag), .i_b_real(i_b_real), .i_b_imag(i_b_imag),
      .i_w_real(i_w_real), .i_w_imag(i_w_imag), .i_tw_bypass(i_tw_bypass), .i_scale(i_scale),
      .i_ovf_clr(i_ovf_clr), .o_valid(o_valid), .i_ready(i_ready),
      .o_sum_real(o_sum_real), .o_sum_imag(o_sum_imag), .o_diff_real(o_diff_real),
      .o_diff_imag(o_diff_imag), .o_ovf(o_ovf)
   );

   function automatic longint fdiv(longint x, longint d);
      return (x >= 0) ? x / d : -((-x + d - 1) / d);
   endfunction

   function automatic longint clampv(longint x, int w, output bit f);
      longint hi;
      hi = (longint'(1) << (w - 1)) - 1;
      f  = (x > hi) || (x < -hi - 1);
      return (x > hi) ? hi : (x < -hi - 1) ? -hi - 1 : x;
   endfunction

   function automatic longint outv(longint x, bit scl, output bit f);
      return clampv(scl ? fdiv(x + 1, 2) : x, DW, f);
   endfunction

   function automatic res_t model(smp_t s);
      res_t r;
      bit f, any;
      longint wb_r, wb_i;
      any = 1'b0;
      if (s.byp) begin
         wb_r = s.br;
         wb_i = s.bi;
      end else begin
         wb_r = clampv(fdiv(longint'(s.br) * s.wr - longint'(s.bi) * s.wi + HALF, ONE), DW + 1, f); any |= f;
         wb_i = clampv(fdiv(longint'(s.br) * s.wi + longint'(s.bi) * s.wr + HALF, ONE), DW + 1, f); any |= f;
      end
      r.sr = int'(outv(s.ar + wb_r, s.scl, f)); any |= f;
      r.si = int'(outv(s.ai + wb_i, s.scl, f)); any |= f;
      r.dr = int'(outv(s.ar - wb_r, s.scl, f)); any |= f;
      r.di = int'(outv(s.ai - wb_i, s.scl, f)); any |= f;
      r.ovf = any;
      return r;
   endfunction

   function automatic int rv(int w);
      case ($urandom_range(0, 5))
         0: return (1 << (w - 1)) - 1;
         1: return -(1 << (w - 1));
         default: return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
      endcase
   endfunction

   function automatic smp_t rsmp();
      smp_t s;
      s.ar = rv(DW); s.ai = rv(DW); s.br = rv(DW); s.bi = rv(DW);
      s.wr = rv(TW); s.wi = rv(TW);
      s.byp = ($urandom_range(0, 3) == 0);
      s.scl = $urandom_range(0, 1);
      return s;
   endfunction

   task automatic cycle(input smp_t s, input bit v, input bit rdy, input bit clr, output bit acc, output bit tk);
      @(negedge clk);
      i_valid = v; i_ready = rdy; i_ovf_clr = clr;
      i_a_real = DW'(s.ar); i_a_imag = DW'(s.ai); i_b_real = DW'(s.br); i_b_imag = DW'(s.bi);
      i_w_real = TW'(s.wr); i_w_imag = TW'(s.wi); i_tw_bypass = s.byp; i_scale = s.scl;
      #1;
      acc = v && o_ready;
      tk  = o_valid && rdy;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b0 || o_ovf !== 1'b0 || {o_sum_real, o_sum_imag, o_diff_real, o_diff_imag} !== '0) begin
         n_fail++;
         $display("FAIL reset: valid=%b ovf=%b sum=(%0d,%0d) diff=(%0d,%0d), want all 0",
                  o_valid, o_ovf, o_sum_real, o_sum_imag, o_diff_real, o_diff_imag);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      smp_t vin[4] = '{'{1000, -500, 200, 300, 16384, 0, 1'b0, 1'b0},
                       '{1000, -500, 200, 300, 0, -16384, 1'b0, 1'b0},
                       '{1001, -3, 0, 0, 5, 5, 1'b1, 1'b1},
                       '{32767, -32768, 32767, 32767, 0, 0, 1'b1, 1'b0}};
      res_t vexp[4] = '{'{1200, -200, 800, -800, 1'b0}, '{1300, -700, 700, -300, 1'b0},
                        '{501, -1, 501, -1, 1'b0}, '{32767, -1, 0, -32768, 1'b1}};
      bit acc, tk;
      int lat;
      for (int i = 0; i < 4; i++) begin
         cycle(vin[i], 1'b1, 1'b1, 1'b0, acc, tk);
         lat = 0;
         do begin
            cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
            lat++;
         end while (!o_valid && lat < 10);
         n_tests++;
         if (lat != 3) begin
            n_fail++;
            $display("FAIL latency[%0d]: got %0d cycles, want 3", i, lat);
         end
         n_tests++;
         if (int'(o_sum_real) !== vexp[i].sr || int'(o_sum_imag) !== vexp[i].si ||
             int'(o_diff_real) !== vexp[i].dr || int'(o_diff_imag) !== vexp[i].di || o_ovf !== vexp[i].ovf) begin
            n_fail++;
            $display("FAIL directed[%0d]: got sum=(%0d,%0d) diff=(%0d,%0d) ovf=%b, want (%0d,%0d) (%0d,%0d) %b", i,
                     o_sum_real, o_sum_imag, o_diff_real, o_diff_imag, o_ovf,
                     vexp[i].sr, vexp[i].si, vexp[i].dr, vexp[i].di, vexp[i].ovf);
         end
      end
   endtask

   task automatic test_ovf_sticky();
      smp_t sat = '{32767, 0, 32767, 0, 0, 0, 1'b1, 1'b0};
      bit acc, tk;
      repeat (3) cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
      n_tests++;
      if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b, want 1", o_ovf); end
      cycle(z, 1'b0, 1'b1, 1'b1, acc, tk);
      cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
      n_tests++;
      if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, want 0", o_ovf); end
      cycle(sat, 1'b1, 1'b1, 1'b0, acc, tk);
      cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
      cycle(z, 1'b0, 1'b1, 1'b1, acc, tk);
      n_tests++;
      if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, want 0", o_ovf); end
      cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
      n_tests++;
      if (o_ovf !== 1'b1 || o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got ovf=%b valid=%b, want 1 1", o_ovf, o_valid);
      end
      cycle(z, 1'b0, 1'b1, 1'b1, acc, tk);
      cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
      n_tests++;
      if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2: got %b, want 0", o_ovf); end
      sticky = 1'b0;
   endtask

   task automatic test_random();
      bit acc, tk, v, rdy;
      smp_t s;
      int outs = 0;
      for (int c = 0; c < 400; c++) begin
         v   = (c < 300) && ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         s   = rsmp();
         cycle(s, v, rdy, 1'b0, acc, tk);
         if (o_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_spurious: o_valid=1 with no sample outstanding (cycle %0d)", c);
            end else if (int'(o_sum_real) !== exp_q[0].sr || int'(o_sum_imag) !== exp_q[0].si ||
                         int'(o_diff_real) !== exp_q[0].dr || int'(o_diff_imag) !== exp_q[0].di ||
                         o_ovf !== (sticky | exp_q[0].ovf)) begin
               n_fail++;
               $display("FAIL rand[%0d]: got sum=(%0d,%0d) diff=(%0d,%0d) ovf=%b, want (%0d,%0d) (%0d,%0d) %b", outs,
                        o_sum_real, o_sum_imag, o_diff_real, o_diff_imag, o_ovf,
                        exp_q[0].sr, exp_q[0].si, exp_q[0].dr, exp_q[0].di, sticky | exp_q[0].ovf);
            end
         end
         if (tk && exp_q.size() > 0) begin
            sticky |= exp_q[0].ovf;
            void'(exp_q.pop_front());
            outs++;
         end
         if (acc) exp_q.push_back(model(s));
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: %0d samples never emerged, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_stall();
      smp_t s[8];
      res_t e[8];
      bit acc, tk, rdy;
      int k = 0;
      int got = 0;
      for (int i = 0; i < 8; i++) begin s[i] = rsmp(); e[i] = model(s[i]); end
      for (int c = 0; c < 40 && got < 8; c++) begin
         rdy = !(c >= 4 && c <= 6);
         cycle((k < 8) ? s[k] : z, k < 8, rdy, 1'b0, acc, tk);
         n_tests++;
         if (o_ready !== !(o_valid && !rdy)) begin
            n_fail++;
            $display("FAIL stall_ready[c%0d]: got o_ready=%b, want %b", c, o_ready, !(o_valid && !rdy));
         end
         if (tk) begin
            n_tests++;
            if (got >= 8 || int'(o_sum_real) !== e[got].sr || int'(o_sum_imag) !== e[got].si ||
                int'(o_diff_real) !== e[got].dr || int'(o_diff_imag) !== e[got].di) begin
               n_fail++;
               $display("FAIL stall_data[%0d]: got sum=(%0d,%0d) diff=(%0d,%0d), want (%0d,%0d) (%0d,%0d)", got,
                        o_sum_real, o_sum_imag, o_diff_real, o_diff_imag,
                        e[got%8].sr, e[got%8].si, e[got%8].dr, e[got%8].di);
            end
            got++;
         end
         if (acc) k++;
      end
      n_tests++;
      if (got != 8) begin n_fail++; $display("FAIL stall_count: got %0d outputs, want 8", got); end
   endtask

   task automatic test_reset_mid();
      bit acc, tk;
      int lat;
      int seen = 0;
      smp_t s;
      res_t e;
      for (int i = 0; i < 3; i++) cycle(rsmp(), 1'b1, 1'b1, 1'b0, acc, tk);
      @(negedge clk);
      i_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (o_valid !== 1'b0 || o_ovf !== 1'b0 || {o_sum_real, o_sum_imag, o_diff_real, o_diff_imag} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: valid=%b ovf=%b outputs nonzero=%b, want 0 0 0", o_valid, o_ovf,
                  |{o_sum_real, o_sum_imag, o_diff_real, o_diff_imag});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
         if (o_valid) seen++;
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL reset_flush: %0d stale outputs, want 0", seen); end
      s = rsmp();
      e = model(s);
      cycle(s, 1'b1, 1'b1, 1'b0, acc, tk);
      lat = 0;
      do begin
         cycle(z, 1'b0, 1'b1, 1'b0, acc, tk);
         lat++;
      end while (!o_valid && lat < 10);
      n_tests++;
      if (lat != 3 || int'(o_sum_real) !== e.sr || int'(o_sum_imag) !== e.si ||
          int'(o_diff_real) !== e.dr || int'(o_diff_imag) !== e.di) begin
         n_fail++;
         $display("FAIL reset_new: lat=%0d sum=(%0d,%0d) diff=(%0d,%0d), want 3 (%0d,%0d) (%0d,%0d)", lat,
                  o_sum_real, o_sum_imag, o_diff_real, o_diff_imag, e.sr, e.si, e.dr, e.di);
      end
   endtask

   initial begin
      i_valid = 1'b0; i_ready = 1'b1; i_ovf_clr = 1'b0; i_tw_bypass = 1'b0; i_scale = 1'b0;
      i_a_real = '0; i_a_imag = '0; i_b_real = '0; i_b_imag = '0; i_w_real = '0; i_w_imag = '0;
      test_reset();
      test_directed();
      test_ovf_sticky();
      test_random();
      test_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
